// File: rtl/arf086b128e1r1w0cbbehsaa4acw_latch_array_pkg.sv
// Shared types and default geometry for the latch-based register-file array.
package arf086b128e1r1w0cbbehsaa4acw_latch_array_pkg;

  localparam int DWIDTH_DEF = 86;
  localparam int DEPTH_DEF  = 128;

  // Array-level state: sweeping INIT_VAL into every entry, or serving traffic
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

endpackage

// File: rtl/arf086b128e1r1w0cbbehsaa4acw_latch_phase_b.sv
// Phase-B storage cell: transparent while en is low, holds while en is high.
// The array drives en = clk | ~sel, so a selected entry opens in the low
// phase and is closed again before the next rising edge.
module arf086b128e1r1w0cbbehsaa4acw_latch_phase_b #(
  parameter int DWIDTH = 86
) (
  input  logic              en,
  input  logic [DWIDTH-1:0] d,
  output logic [DWIDTH-1:0] q
);

  // Level-sensitive capture of the write-stage data
  always_latch begin
    if (!en) q <= d;
  end

endmodule

// File: rtl/arf086b128e1r1w0cbbehsaa4acw_latch_array.sv
// 1-read/1-write latch register-file array with hardware init sweep,
// flopped write stage feeding phase-B latches, and optional same-edge bypass.
module arf086b128e1r1w0cbbehsaa4acw_latch_array
  import arf086b128e1r1w0cbbehsaa4acw_latch_array_pkg::*;
#(
  parameter int                DWIDTH   = DWIDTH_DEF,
  parameter int                DEPTH    = DEPTH_DEF,
  parameter int                AWIDTH   = $clog2(DEPTH),
  parameter logic [DWIDTH-1:0] INIT_VAL = '0,
  parameter bit                BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_req,
  output logic              ready,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  output logic              wr_drop,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_data,
  output logic              rd_valid
);

  localparam logic [AWIDTH:0]   DEPTH_W  = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH-1:0] CNT_LAST = AWIDTH'(DEPTH - 1);

  state_t              state;
  logic [AWIDTH-1:0]   cnt;

  // Write stage: one registered slot shared by the sweep and user writes
  logic                wr_vld_p0;
  logic [AWIDTH-1:0]   wr_addr_p0;
  logic [DWIDTH-1:0]   wr_data_p0;

  logic [DWIDTH-1:0]   mem [DEPTH];

  logic                wr_in_range;
  logic                rd_in_range;
  logic                wr_accept;
  logic [DWIDTH-1:0]   rd_next;

  assign wr_in_range = {1'b0, wr_addr} < DEPTH_W;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_W;
  // A user write only gets the write stage when the sweep does not own it
  assign wr_accept   = (state == ST_IDLE) && !init_req && wr_en && wr_in_range;

  // FSM, sweep counter and registered ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      ready <= (state == ST_IDLE) && !init_req;
      case (state)
        ST_INIT: begin
          if (init_req) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + AWIDTH'(1);
          end
        end
        ST_IDLE: begin
          if (init_req) begin
            state <= ST_INIT;
            cnt   <= '0;
          end
        end
        default: begin
          state <= ST_INIT;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Write-stage control: valid and drop indication are reset so no latch opens during reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_vld_p0 <= 1'b0;
      wr_drop   <= 1'b0;
    end else begin
      wr_vld_p0 <= (state == ST_INIT) || wr_accept;
      wr_drop   <= wr_en && !wr_accept;
    end
  end

  // Write-stage datapath: sweep pattern while initialising, user data otherwise
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      wr_addr_p0 <= cnt;
      wr_data_p0 <= INIT_VAL;
    end else begin
      wr_addr_p0 <= wr_addr;
      wr_data_p0 <= wr_data;
    end
  end

  // One-hot decode from flopped signals only, so enables are glitch-free while clk is low
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic sel;
    logic en;
    assign sel = wr_vld_p0 && (wr_addr_p0 == AWIDTH'(i));
    assign en  = clk | ~sel;
    arf086b128e1r1w0cbbehsaa4acw_latch_phase_b #(
      .DWIDTH(DWIDTH)
    ) u_cell (
      .en (en),
      .d  (wr_data_p0),
      .q  (mem[i])
    );
  end

  // Read mux with init masking and same-edge forwarding of an accepted write
  always_comb begin
    rd_next = INIT_VAL;
    if (state == ST_INIT) begin
      rd_next = INIT_VAL;
    end else if (BYPASS && wr_accept && (wr_addr == rd_addr)) begin
      rd_next = wr_data;
    end else if (rd_in_range) begin
      rd_next = mem[rd_addr];
    end
  end

  // Registered read port; data holds when no read is requested
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_next;
    end
  end

endmodule

// File: tb/tb_arf086b128e1r1w0cbbehsaa4acw_latch_array.sv
// Directed bench for the latch register-file array with a behavioural model.
module tb_arf086b128e1r1w0cbbehsaa4acw_latch_array;

  localparam int DW    = 86;
  localparam int DEPTH = 128;
  localparam int AW    = 7;
  localparam logic [DW-1:0] INIT = '0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init_req = 1'b0;
  logic          ready;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_drop;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  arf086b128e1r1w0cbbehsaa4acw_latch_array dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .init_req (init_req),
    .ready    (ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_drop  (wr_drop),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  task automatic lit(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: the array is "initialising" for every edge up to
  // last_sw (DEPTH edges after reset release or after an init_req edge);
  // user writes live in a sparse map that any new sweep wipes.
  logic [DW-1:0] mm [int];
  int            e_no = 0;
  int            last_sw = DEPTH;
  logic          exp_ready = 1'b0;
  logic          exp_drop = 1'b0;
  logic          exp_valid = 1'b0;
  logic [DW-1:0] exp_rd = '0;
  logic          m_init;
  logic          m_acc;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        e_no = 0;
        last_sw = DEPTH;
        mm.delete();
        exp_ready = 1'b0;
        exp_drop = 1'b0;
        exp_valid = 1'b0;
        exp_rd = '0;
      end else begin
        e_no = e_no + 1;
        m_init = (e_no <= last_sw);
        m_acc = !m_init && !init_req && wr_en;
        exp_drop = wr_en && !m_acc;
        exp_valid = rd_en;
        if (rd_en) begin
          if (m_init) exp_rd = INIT;
          else if (m_acc && wr_addr == rd_addr) exp_rd = wr_data;
          else if (mm.exists(int'(rd_addr))) exp_rd = mm[int'(rd_addr)];
          else exp_rd = INIT;
        end
        exp_ready = !m_init && !init_req;
        if (init_req) begin
          last_sw = e_no + DEPTH;
          mm.delete();
        end
        if (m_acc) mm[int'(wr_addr)] = wr_data;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  initial begin
    forever begin
      @(posedge clk);
      #2;
      lit("ready", ready, exp_ready);
      lit("wr_drop", wr_drop, exp_drop);
      lit("rd_valid", rd_valid, exp_valid);
      lit("rd_data", rd_data, exp_rd);
    end
  end

  task automatic step(input logic ir, input logic we, input int wa, input logic [DW-1:0] wd,
                      input logic re, input int ra);
    init_req = ir;
    wr_en    = we;
    wr_addr  = AW'(wa);
    wr_data  = wd;
    rd_en    = re;
    rd_addr  = AW'(ra);
    @(posedge clk);
    #3;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, '0, 1'b0, 0);
  endtask

  initial begin
    // reset held for two edges
    @(posedge clk); #3;
    @(posedge clk); #3;
    lit("rst_ready", ready, 0);
    lit("rst_rd_valid", rd_valid, 0);
    lit("rst_rd_data", rd_data, 0);
    lit("rst_wr_drop", wr_drop, 0);
    rst_n = 1'b1;

    // sweep: reads every cycle, two back-to-back writes that must be dropped
    for (int k = 1; k <= DEPTH; k++) begin
      step(1'b0, (k == 10 || k == 11), k, 86'h3AB, 1'b1, k % DEPTH);
      if (k == 10) lit("drop_in_init", wr_drop, 1);
      if (k == 11) lit("drop_b2b", wr_drop, 1);
      if (k == 20) begin
        lit("init_rd_valid", rd_valid, 1);
        lit("init_rd_data", rd_data, 0);
      end
      if (k == DEPTH) lit("ready_low_at_depth", ready, 0);
    end
    idle(1);
    lit("ready_high_at_depth_p1", ready, 1);

    // every entry reads INIT_VAL after the sweep
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 0, '0, 1'b1, i);
    lit("last_entry_init", rd_data, 0);

    // write then read on the next edge
    step(1'b0, 1'b1, 5, 86'h2A5, 1'b0, 0);
    step(1'b0, 1'b0, 0, '0, 1'b1, 5);
    lit("rd_addr5", rd_data, 86'h2A5);
    lit("rd_addr5_valid", rd_valid, 1);
    step(1'b0, 1'b1, 0, 86'h1_0000_0000_0000_0000_0001, 1'b0, 0);
    step(1'b0, 1'b0, 0, '0, 1'b1, 0);
    lit("rd_addr0", rd_data, 86'h1_0000_0000_0000_0000_0001);
    step(1'b0, 1'b1, DEPTH-1, 86'h3F_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b0, 0);
    step(1'b0, 1'b0, 0, '0, 1'b1, DEPTH-1);
    lit("rd_addr_last", rd_data, 86'h3F_FFFF_FFFF_FFFF_FFFF_FFFF);

    // concurrent write/read to different entries, then same-edge bypass
    step(1'b0, 1'b1, 7, 86'hABC, 1'b1, 5);
    lit("rd_while_wr", rd_data, 86'h2A5);
    step(1'b0, 1'b1, 7, 86'h1234, 1'b1, 7);
    lit("bypass_same_edge", rd_data, 86'h1234);
    step(1'b0, 1'b0, 0, '0, 1'b1, 7);
    lit("after_bypass_stored", rd_data, 86'h1234);
    step(1'b0, 1'b0, 0, '0, 1'b0, 7);
    lit("hold_valid", rd_valid, 0);
    lit("hold_data", rd_data, 86'h1234);

    // write alongside init_req is dropped; restart the sweep at cnt=40
    step(1'b1, 1'b1, 9, 86'h777, 1'b0, 0);
    lit("drop_with_init_req", wr_drop, 1);
    lit("ready_fall", ready, 0);
    idle(40);
    step(1'b1, 1'b0, 0, '0, 1'b0, 0);
    idle(DEPTH);
    lit("restart_ready_low", ready, 0);
    idle(1);
    lit("restart_ready_high", ready, 1);
    step(1'b0, 1'b0, 0, '0, 1'b1, 9);
    lit("dropped_entry_init", rd_data, 0);
    step(1'b0, 1'b0, 0, '0, 1'b1, 5);
    lit("swept_entry_init", rd_data, 0);

    // asynchronous reset during back-to-back writes
    step(1'b0, 1'b1, 3, 86'hAAA, 1'b0, 0);
    step(1'b0, 1'b1, 4, 86'hBBB, 1'b1, 3);
    lit("pre_reset_rd", rd_data, 86'hAAA);
    wr_en = 1'b1; wr_addr = AW'(5); wr_data = 86'hCCC; rd_en = 1'b1; rd_addr = AW'(4);
    #1;
    rst_n = 1'b0;
    #1;
    lit("async_ready", ready, 0);
    lit("async_rd_valid", rd_valid, 0);
    lit("async_rd_data", rd_data, 0);
    lit("async_wr_drop", wr_drop, 0);
    idle(2);
    rst_n = 1'b1;
    idle(DEPTH);
    lit("post_rst_ready_low", ready, 0);
    idle(1);
    lit("post_rst_ready_high", ready, 1);
    step(1'b0, 1'b0, 0, '0, 1'b1, 3);
    lit("post_rst_e3", rd_data, 0);
    step(1'b0, 1'b0, 0, '0, 1'b1, 4);
    lit("post_rst_e4", rd_data, 0);
    idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
